toy_fetch_queue: RTL and testbench

- Instruction realignment buffer between the instruction-memory response port and fetch/decode.
- Accepts aligned 32-bit memory words and stores them as 16-bit halfwords.
- Delivers one RISC-V instruction per handshake: 16-bit compressed (RVC) or 32-bit, including 32-bit instructions that straddle two memory words.
- Flushed by the fetch redirect (clear).

---
 rtl/toy_fetch_queue_pkg.sv | 8 +
 rtl/toy_fetch_queue.sv | 65 ++++++
 tb/tb_toy_fetch_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/toy_fetch_queue_pkg.sv
// toy_fetch_queue_pkg: shared widths and RVC detection for the fetch realignment queue.
package toy_fetch_queue_pkg;
  localparam int HWORD_WIDTH = 16;
  localparam int INST_WIDTH = 32;
  function automatic logic is_rvc(input logic [HWORD_WIDTH-1:0] h);
    return h[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/toy_fetch_queue.sv
// toy_fetch_queue: halfword ring that realigns 32-bit memory words into RVC/32-bit instructions.
module toy_fetch_queue
  import toy_fetch_queue_pkg::*;
#(
  parameter int  DEPTH    = 32,
  parameter type PLD_TYPE = logic [31:0]
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    req_vld,
  output logic    req_rdy,
  input  PLD_TYPE req_pld,
  input  logic    mis_align_mem_data,
  output logic    ack_vld,
  input  logic    ack_rdy,
  output PLD_TYPE ack_pld
);
  localparam int SLOTS = 2 * DEPTH;
  localparam int AW = $clog2(SLOTS);
  logic [HWORD_WIDTH-1:0] r_mem [SLOTS];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_cnt;
  logic [HWORD_WIDTH-1:0] w_h0, w_h1, w_lo, w_hi;
  logic w_rvc, w_push, w_pop;
  logic [AW:0] w_need, w_npush, w_npop;
  always_comb begin
    w_lo    = req_pld[15:0];
    w_hi    = req_pld[31:16];
    w_h0    = r_mem[r_rptr];
    w_h1    = r_mem[r_rptr + AW'(1)];
    w_rvc   = is_rvc(w_h0);
    w_need  = w_rvc ? (AW+1)'(1) : (AW+1)'(2);
    req_rdy = r_cnt <= (AW+1)'(SLOTS - 2);
    ack_vld = r_cnt >= w_need;
    ack_pld = r_cnt == '0 ? PLD_TYPE'(0) : w_rvc ? PLD_TYPE'({16'h0, w_h0}) : PLD_TYPE'({w_h1, w_h0});
    w_push  = req_vld && req_rdy && !clear;
    w_pop   = ack_vld && ack_rdy && !clear;
    w_npush = !w_push ? '0 : mis_align_mem_data ? (AW+1)'(1) : (AW+1)'(2);
    w_npop  = w_pop ? w_need : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= r_wptr + w_npush[AW-1:0];
      r_rptr <= r_rptr + w_npop[AW-1:0];
      r_cnt  <= r_cnt + w_npush - w_npop;
    end
  // Misaligned words keep only the upper halfword; the lower one belongs to the previous PC.
  always_ff @(posedge clk)
    if (w_push) begin
      if (mis_align_mem_data) r_mem[r_wptr] <= w_hi;
      else begin
        r_mem[r_wptr]          <= w_lo;
        r_mem[r_wptr + AW'(1)] <= w_hi;
      end
    end
endmodule

// File: tb/tb_toy_fetch_queue.sv
// tb_toy_fetch_queue: directed stimulus with an expected-instruction scoreboard checked by a monitor.
module tb_toy_fetch_queue;
  logic clk = 0, rst_n = 0, clear = 0, req_vld = 0, mis = 0, ack_rdy = 0;
  logic [31:0] req_pld = '0;
  logic req_rdy, ack_vld;
  logic [31:0] ack_pld;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  toy_fetch_queue #(.DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_pld(req_pld), .mis_align_mem_data(mis), .ack_vld(ack_vld), .ack_rdy(ack_rdy),
    .ack_pld(ack_pld)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  always @(negedge clk)
    if (rst_n && ack_vld && ack_rdy && !clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack act=%h req=none", ack_pld);
      end else check("ack_pld", ack_pld, exp_q.pop_front());
    end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic m);
    int n = 0;
    while (!req_rdy && n < 200) begin
      idle(1);
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout act=req_rdy0 req=req_rdy1");
    end
    req_vld = 1;
    req_pld = w;
    mis = m;
    idle(1);
    req_vld = 0;
    mis = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (ack_vld && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_done", {31'b0, ack_vld}, 32'd0);
  endtask

  initial begin
    logic [31:0] words[4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
    int n;
    #2;
    check("rst_async_ack_vld", {31'b0, ack_vld}, 32'd0);
    idle(2);
    rst_n = 1;
    check("rst_ack_vld", {31'b0, ack_vld}, 32'd0);
    check("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("rst_ack_pld", ack_pld, 32'd0);
    // aligned 32-bit stream, each visible the cycle after its push
    ack_rdy = 1;
    idle(1);
    check("empty_ignores_ack", {31'b0, ack_vld}, 32'd0);
    foreach (words[i]) begin
      exp_q.push_back(words[i]);
      push_word(words[i], 0);
      check("latency_vld", {31'b0, ack_vld}, 32'd1);
      check("latency_pld", ack_pld, words[i]);
    end
    idle(1);
    check("aligned_empty", {31'b0, ack_vld}, 32'd0);
    // RVC mix
    exp_q.push_back(32'h00004501);
    exp_q.push_back(32'h00004501);
    exp_q.push_back(32'h00000013);
    push_word(32'h45014501, 0);
    push_word(32'h00000013, 0);
    idle(4);
    check("rvc_empty", {31'b0, ack_vld}, 32'd0);
    // straddle across words
    exp_q.push_back(32'h00004501);
    push_word(32'h00134501, 0);
    idle(1);
    check("straddle_wait", {31'b0, ack_vld}, 32'd0);
    check("straddle_rdy", {31'b0, req_rdy}, 32'd1);
    exp_q.push_back(32'h00000013);
    exp_q.push_back(32'h00000000);
    push_word(32'h00000000, 0);
    check("straddle_join", ack_pld, 32'h00000013);
    idle(3);
    check("straddle_empty", {31'b0, ack_vld}, 32'd0);
    // misaligned word keeps only upper half
    exp_q.push_back(32'h00004501);
    push_word(32'h4501FFFF, 1);
    idle(3);
    check("misalign_empty", {31'b0, ack_vld}, 32'd0);
    // fill to full, drain, refill across wrap
    ack_rdy = 0;
    n = 0;
    while (req_rdy && n < 40) begin
      exp_q.push_back(32'h00000013 | (n << 20));
      push_word(32'h00000013 | (n << 20), 0);
      n++;
    end
    check("fill_words", n, 32'd32);
    check("full_req_rdy", {31'b0, req_rdy}, 32'd0);
    check("full_ack_vld", {31'b0, ack_vld}, 32'd1);
    ack_rdy = 1;
    wait_empty();
    ack_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(32'h00000093 | (i << 20));
      push_word(32'h00000093 | (i << 20), 0);
    end
    ack_rdy = 1;
    wait_empty();
    check("wrap_sb_empty", exp_q.size(), 32'd0);
    // clear discards queued words, concurrent push and pop
    ack_rdy = 0;
    for (int i = 0; i < 3; i++) push_word(32'h00500293, 0);
    clear = 1;
    req_vld = 1;
    req_pld = 32'hDEADBEEF;
    ack_rdy = 1;
    check("preclear_ack_vld", {31'b0, ack_vld}, 32'd1);
    idle(1);
    clear = 0;
    req_vld = 0;
    ack_rdy = 0;
    check("clear_ack_vld", {31'b0, ack_vld}, 32'd0);
    check("clear_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("clear_ack_pld", ack_pld, 32'd0);
    ack_rdy = 1;
    exp_q.push_back(32'h00000013);
    push_word(32'h00000013, 0);
    idle(3);
    // asynchronous reset mid-stream
    ack_rdy = 0;
    push_word(32'h00600313, 0);
    push_word(32'h00700393, 0);
    #3 rst_n = 0;
    #1;
    check("async_rst_ack_vld", {31'b0, ack_vld}, 32'd0);
    check("async_rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("async_rst_ack_pld", ack_pld, 32'd0);
    idle(1);
    rst_n = 1;
    idle(2);
    check("post_rst_ack_vld", {31'b0, ack_vld}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
